usr_cmd_sequencer: RTL and testbench
====================================

# usr_cmd_sequencer

Command-driven controller for the 4-bit universal shift register. It accepts one command at a time over a valid/ready handshake: parallel load, logical, rotate, arithmetic or serial-in shift by N positions. It then drives the register's mode-select, parallel-data and serial-fill inputs for the required number of cycles. It sits between a host/control FSM and the register, which shares the same clock and clear, and returns the register contents with a one-cycle done pulse.

## Interface
- DATA_WIDTH, 4, width of the controlled shift register.
- CNT_WIDTH, 3, width of the shift-count field; max count 2**CNT_WIDTH-1.
- i_clk  in  1  single clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-high; the same net also clears the shift register.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  opcode: 000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROR, 101 ROL, 110 SERIN, 111 ASR.
- cmd_cnt  in  CNT_WIDTH  number of shift positions; ignored for NOP/LOAD.
- cmd_data  in  DATA_WIDTH  parallel load value; used by LOAD only.
- ser_in  in  1  serial data for SERIN, sampled every SHIFT cycle.
- reg_q  in  DATA_WIDTH  shift register output.
- sel_mux  out  2  register mode: 00 hold, 01 shift right (sr enters MSB, bit 0 dropped), 10 shift left (sl enters LSB, MSB dropped), 11 parallel load.
- in  out  DATA_WIDTH  parallel data to register.
- sr  out  1  fill bit for right shifts.
- sl  out  1  fill bit for left shifts.
- busy  out  1  command in progress (state != IDLE).
- done  out  1  one-cycle pulse, command complete.
- result  out  DATA_WIDTH  equals reg_q; valid while done=1.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, sel_mux=00.
  - On cmd_valid&cmd_ready: latch op, cnt and data.
  - Next state: LOAD for op LOAD; DONE for NOP or cnt==0; otherwise SHIFT with remaining=cnt.
- LOAD: sel_mux=11, in=latched data for one cycle, then DONE.
- SHIFT:
  - One register shift per cycle; remaining decrements each cycle.
  - When remaining==1, next state is DONE.
  - Direction and fill per op:
    - SHR: 01, sr=0.
    - SHL: 10, sl=0.
    - ROR: 01, sr=reg_q[0].
    - ROL: 10, sl=reg_q[DATA_WIDTH-1].
    - SERIN: 01, sr=ser_in.
    - ASR: 01, sr=reg_q[DATA_WIDTH-1].
- DONE: sel_mux=00, done=1, result=reg_q; next state IDLE.
- Output decode:
  - sel_mux, in, sr and sl decode from state and latched op only; no combinational path from cmd_* inputs.
  - Unused fill bits are 0; in=0 outside LOAD.
- cmd_ready=0 in LOAD/SHIFT/DONE. cmd_valid there is ignored; the host holds the command until accepted.
- Register is never driven in a non-hold mode outside LOAD/SHIFT.

## Timing
- Reset values (clr=1, asynchronous):
  - State IDLE, cmd_ready=1, busy=0, done=0.
  - sel_mux=00, in=0, sr=0, sl=0.
  - Latched op/cnt/data cleared; result follows reg_q (0 under clr).
- Accept at edge T:
  - LOAD: LOAD cycle T..T+1, done high T+1..T+2, ready again T+2.
  - Shift by N≥1: SHIFT N cycles, done in cycle N+1 after accept, ready at N+2.
  - NOP or cnt==0: done in cycle after accept; register unchanged.
- Throughput: one command per N+2 cycles (LOAD counts as N=1).
- clr mid-command: immediate return to IDLE, no done pulse, register cleared; the next command is accepted normally after clr deasserts.
- cnt = max (7) executes exactly 7 shifts; counter must not wrap.

## Test plan
- Reset, then LOAD data=1011 → sel_mux=11 one cycle; done pulse with result=1011 two cycles after accept.
- From 1011: ROR cnt=1 → 1101. ROL cnt=3 from 1011 → 1101 with intermediates 0111, 1110.
- SHR cnt=2 from 1101 → 0011. ASR cnt=2 from 1000 → 1110. SHL cnt=7 from 1111 → 0000, done exactly 8 cycles after accept.
- SERIN cnt=4 from 0000, ser_in=1,0,0,1 → 1000, 0100, 0010, 1001; result=1001.
- NOP and ROR cnt=0 → done next cycle, register unchanged. cmd_valid held during busy → not accepted until cmd_ready=1, executed exactly once.
- clr asserted in 3rd cycle of a cnt=6 SHL → outputs at reset values at once, no done; a following LOAD 0110 completes normally.

Source files
------------

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer for a 4-bit universal shift register: accepts one command over valid/ready
// and drives mode/data/fill for the number of cycles the command needs, then pulses done.
module usr_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  clr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_WIDTH-1:0]  cmd_cnt,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  ser_in,
  input  logic [DATA_WIDTH-1:0] reg_q,
  output logic [1:0]            sel_mux,
  output logic [DATA_WIDTH-1:0] in,
  output logic                  sr,
  output logic                  sl,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpLoad  = 3'b001;
  localparam logic [2:0] OpShl   = 3'b011;
  localparam logic [2:0] OpRor   = 3'b100;
  localparam logic [2:0] OpRol   = 3'b101;
  localparam logic [2:0] OpSerin = 3'b110;
  localparam logic [2:0] OpAsr   = 3'b111;

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            sel_mux_q, sel_mux_d;
  logic [DATA_WIDTH-1:0] in_q, in_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  function automatic logic [1:0] shift_mode(input logic [2:0] op);
    return ((op == OpShl) || (op == OpRol)) ? ModeLeft : ModeRight;
  endfunction

  // cnt_q holds the number of shifts still to perform, including the current cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          cnt_d  = cmd_cnt;
          data_d = cmd_data;
          if (cmd_op == OpLoad) begin
            state_d = StLoad;
          end else if ((cmd_op == OpNop) || (cmd_cnt == '0)) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StLoad:  state_d = StDone;
      StShift: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    sel_mux_d = ModeHold;
    in_d      = '0;
    unique case (state_d)
      StLoad: begin
        sel_mux_d = ModeLoad;
        in_d      = data_d;
      end
      StShift: sel_mux_d = shift_mode(op_d);
      default: ;
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge i_clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      op_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      sel_mux_q <= ModeHold;
      in_q      <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      sel_mux_q <= sel_mux_d;
      in_q      <= in_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Fill bits depend on the live register contents, so they cannot be registered ahead.
  always_comb begin
    sr = 1'b0;
    sl = 1'b0;
    if (state_q == StShift) begin
      unique case (op_q)
        OpRor:   sr = reg_q[0];
        OpSerin: sr = ser_in;
        OpAsr:   sr = reg_q[DATA_WIDTH-1];
        OpRol:   sl = reg_q[DATA_WIDTH-1];
        default: ;
      endcase
    end
  end

  assign sel_mux   = sel_mux_q;
  assign in        = in_q;
  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = reg_q;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer: drives a behavioural 4-bit universal shift register and checks
// each command's result, intermediate values, mode and latency against an arithmetic model.
module tb_usr_cmd_sequencer;

  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_SHR = 3'd2, OP_SHL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4, OP_ROL = 3'd5, OP_SERIN = 3'd6, OP_ASR = 3'd7;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [2:0] cmd_cnt = '0;
  logic [3:0] cmd_data = '0;
  logic       ser_in = 1'b0;
  logic [3:0] plant_q;
  logic [1:0] sel_mux;
  logic [3:0] par_in;
  logic       sr, sl, busy, done;
  logic [3:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] model_q = '0;

  always #5 clk = ~clk;

  usr_cmd_sequencer #(.DATA_WIDTH(4), .CNT_WIDTH(3)) dut (
    .i_clk    (clk),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .cmd_data (cmd_data),
    .ser_in   (ser_in),
    .reg_q    (plant_q),
    .sel_mux  (sel_mux),
    .in       (par_in),
    .sr       (sr),
    .sl       (sl),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // The controlled universal shift register, sharing clock and clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) plant_q <= '0;
    else begin
      case (sel_mux)
        2'b01:   plant_q <= {sr, plant_q[3:1]};
        2'b10:   plant_q <= {plant_q[2:0], sl};
        2'b11:   plant_q <= par_in;
        default: plant_q <= plant_q;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register value after n steps of op applied to start.
  function automatic logic [3:0] model(input logic [2:0] op, input int n, input logic [3:0] data,
                                       input logic [3:0] start, input logic [7:0] bits);
    int v = start;
    int k = n % 4;
    int s;
    case (op)
      OP_LOAD:  v = (n > 0) ? int'(data) : v;
      OP_SHR:   v = v >> n;
      OP_SHL:   v = (v << n) & 15;
      OP_ROR:   v = ((v >> k) | (v << (4 - k))) & 15;
      OP_ROL:   v = ((v << k) | (v >> (4 - k))) & 15;
      OP_ASR: begin
        s = (v >= 8) ? v - 16 : v;
        s = s >>> n;
        v = s & 15;
      end
      OP_SERIN: for (int i = 0; i < n; i++) v = (int'(bits[i]) << 3) | (v >> 1);
      default:  v = v;
    endcase
    return 4'(v);
  endfunction

  function automatic int steps(input logic [2:0] op, input logic [2:0] cnt);
    if (op == OP_NOP) return 0;
    if (op == OP_LOAD) return 1;
    return int'(cnt);
  endfunction

  task automatic accept(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data);
    int waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    while (!cmd_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) check_eq("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_cnt   = '0;
    cmd_data  = '0;
  endtask

  // Called #1 after the accepting edge; walks the command to its done pulse.
  task automatic complete(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data,
                          input logic [7:0] bits, input string tag);
    int n = steps(op, cnt);
    logic [3:0] start = model_q;
    logic [3:0] exp = model(op, n, data, start, bits);
    logic [1:0] mode = (op == OP_LOAD) ? 2'b11 : ((op == OP_SHL || op == OP_ROL) ? 2'b10 : 2'b01);
    int lat = -1;
    for (int i = 0; i < 20; i++) begin
      ser_in = bits[i % 8];
      if (done) begin
        lat = i;
        break;
      end
      check_eq({tag, "_mode"}, sel_mux, mode);
      check_eq({tag, "_in"}, par_in, (op == OP_LOAD) ? data : 4'd0);
      check_eq({tag, "_mid"}, result, model(op, i, data, start, bits));
      check_eq({tag, "_rdy"}, cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_lat"}, lat, n);
    check_eq({tag, "_res"}, result, exp);
    check_eq({tag, "_dsel"}, sel_mux, 0);
    check_eq({tag, "_dbusy"}, busy, 1);
    model_q = exp;
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, done, 0);
    check_eq({tag, "_ready"}, cmd_ready, 1);
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data,
                        input logic [7:0] bits, input string tag);
    accept(op, cnt, data);
    complete(op, cnt, data, bits, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, cmd_ready, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_sel"}, sel_mux, 0);
    check_eq({tag, "_in"}, par_in, 0);
    check_eq({tag, "_srsl"}, {sr, sl}, 0);
    check_eq({tag, "_res"}, result, 0);
  endtask

  initial begin
    int dones;
    #2 clr = 1'b1;
    #10;
    check_reset_outputs("reset");
    @(negedge clk);
    clr = 1'b0;

    do_cmd(OP_LOAD, 3'd0, 4'b1011, 8'h00, "load1011");
    do_cmd(OP_ROR, 3'd1, 4'd0, 8'hff, "ror1");
    check_eq("ror1_val", result, 4'b1101);
    do_cmd(OP_LOAD, 3'd0, 4'b1011, 8'h00, "load1011b");
    do_cmd(OP_ROL, 3'd3, 4'd0, 8'h00, "rol3");
    check_eq("rol3_val", result, 4'b1101);
    do_cmd(OP_SHR, 3'd2, 4'd0, 8'hff, "shr2");
    check_eq("shr2_val", result, 4'b0011);
    do_cmd(OP_LOAD, 3'd0, 4'b1000, 8'h00, "load1000");
    do_cmd(OP_ASR, 3'd2, 4'd0, 8'h00, "asr2");
    check_eq("asr2_val", result, 4'b1110);
    do_cmd(OP_LOAD, 3'd0, 4'b1111, 8'h00, "load1111");
    do_cmd(OP_SHL, 3'd7, 4'd0, 8'hff, "shl7");
    check_eq("shl7_val", result, 4'b0000);
    do_cmd(OP_LOAD, 3'd0, 4'b0000, 8'h00, "load0000");
    do_cmd(OP_SERIN, 3'd4, 4'd0, 8'b0000_1001, "serin4");
    check_eq("serin4_val", result, 4'b1001);
    do_cmd(OP_NOP, 3'd5, 4'hf, 8'hff, "nop");
    do_cmd(OP_ROR, 3'd0, 4'hf, 8'hff, "ror0");

    // Second command presented while the first is busy; it must run once, after the first.
    accept(OP_LOAD, 3'd0, 4'b0101);
    cmd_valid = 1'b1;
    cmd_op    = OP_ROR;
    cmd_cnt   = 3'd1;
    complete(OP_LOAD, 3'd0, 4'b0101, 8'h00, "held_a");
    accept(OP_ROR, 3'd1, 4'd0);
    complete(OP_ROR, 3'd1, 4'd0, 8'h00, "held_b");
    check_eq("held_b_val", result, 4'b1010);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check_eq("held_once", dones, 0);
    check_eq("held_keep", result, 4'b1010);

    // Clear in the third cycle of a six-position shift.
    do_cmd(OP_LOAD, 3'd0, 4'b1011, 8'h00, "load_pre_clr");
    accept(OP_SHL, 3'd6, 4'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    check_reset_outputs("clr_mid");
    @(negedge clk);
    clr = 1'b0;
    model_q = '0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check_eq("clr_no_done", dones, 0);
    do_cmd(OP_LOAD, 3'd0, 4'b0110, 8'h00, "load_post_clr");
    check_eq("post_clr_val", result, 4'b0110);

    for (int t = 0; t < 40; t++) begin
      logic [2:0] op = 3'($urandom_range(0, 7));
      logic [2:0] cnt = 3'($urandom_range(0, 7));
      logic [3:0] data = 4'($urandom);
      logic [7:0] bits = 8'($urandom);
      if (t % 5 == 0) op = OP_LOAD;
      do_cmd(op, cnt, data, bits, $sformatf("rnd%0d_op%0d_n%0d", t, op, cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
